// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc front end: field widths, opcode names
// and the fetch FSM state encoding.
package nrisc_pkg;

  localparam int OP_W   = 3;
  localparam int RA_W   = 3;
  localparam int RB_W   = 2;
  localparam int DATA_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_LD  = 3'd4;
  localparam logic [OP_W-1:0] OP_ST  = 3'd5;
  localparam logic [OP_W-1:0] OP_LI  = 3'd6;
  localparam logic [OP_W-1:0] OP_JMP = 3'd7;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_FETCH_IMM = 2'd1,
    ST_HOLD      = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_field_splitter.sv
// Splits one instruction byte into op/reg_a/reg_b and flags opcodes that
// are followed by an immediate byte.
module instr_field_splitter
  import nrisc_pkg::*;
#(
  parameter logic [DATA_W-1:0] IMM_OP_MASK = 8'b1100_0000
) (
  input  logic [DATA_W-1:0] instr_byte,
  output logic [OP_W-1:0]   op,
  output logic [RA_W-1:0]   ra,
  output logic [RB_W-1:0]   rb,
  output logic              needs_imm
);

  assign op        = instr_byte[7:5];
  assign ra        = instr_byte[4:2];
  assign rb        = instr_byte[1:0];
  assign needs_imm = IMM_OP_MASK[instr_byte[7:5]];

endmodule

// File: rtl/instr_fetch_decoder.sv
// Instruction fetch and field decode for the 8-bit nRisc pipeline, with
// two-byte immediate instructions, downstream stall and branch redirect.
module instr_fetch_decoder
  import nrisc_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] IMM_OP_MASK = 8'b1100_0000
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] imem_addr,
  output logic       imem_req,
  input  logic [7:0] imem_data,
  input  logic       imem_ack,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  output logic [2:0] operation,
  output logic [2:0] reg_a,
  output logic [1:0] reg_b,
  output logic [7:0] immediate,
  output logic       instr_valid,
  output logic [7:0] pc_out
);

  fetch_state_e      state;
  logic              pend_imm;
  logic [7:0]        pc;
  logic [7:0]        first_byte;
  logic [7:0]        first_addr;
  logic [OP_W-1:0]   split_op;
  logic [RA_W-1:0]   split_ra;
  logic [RB_W-1:0]   split_rb;
  logic              split_imm;
  logic [DATA_W-1:0] split_byte;
  logic              fetching;
  logic              fire;

  // In FETCH_IMM the fields come from the saved first byte, not the bus.
  assign split_byte = (state == ST_FETCH_IMM) ? first_byte : imem_data;

  instr_field_splitter #(
    .IMM_OP_MASK(IMM_OP_MASK)
  ) u_splitter (
    .instr_byte(split_byte),
    .op        (split_op),
    .ra        (split_ra),
    .rb        (split_rb),
    .needs_imm (split_imm)
  );

  assign imem_addr = pc;
  assign fetching  = (state == ST_FETCH) || (state == ST_FETCH_IMM);
  assign imem_req  = reset && fetching && !branch_taken && (!instr_valid || !stall);
  assign fire      = imem_req && imem_ack;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_FETCH;
      pend_imm    <= 1'b0;
      pc          <= RESET_PC;
      first_byte  <= '0;
      first_addr  <= '0;
      operation   <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      immediate   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      pc          <= branch_target;
      state       <= ST_FETCH;
      pend_imm    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ST_FETCH, ST_FETCH_IMM: begin
          if (fire) begin
            pc <= pc + 8'd1;
            if (state == ST_FETCH && split_imm) begin
              // fire implies the slot is free, so any held instruction is consumed
              first_byte  <= imem_data;
              first_addr  <= pc;
              instr_valid <= 1'b0;
              state       <= ST_FETCH_IMM;
            end else begin
              operation   <= split_op;
              reg_a       <= split_ra;
              reg_b       <= split_rb;
              immediate   <= (state == ST_FETCH_IMM) ? imem_data : 8'h00;
              pc_out      <= (state == ST_FETCH_IMM) ? first_addr : pc;
              instr_valid <= 1'b1;
              state       <= ST_FETCH;
            end
          end else if (instr_valid && stall) begin
            pend_imm <= (state == ST_FETCH_IMM);
            state    <= ST_HOLD;
          end else if (instr_valid) begin
            instr_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            state       <= pend_imm ? ST_FETCH_IMM : ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule
